// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scheduler
// Brief    : Round-robin write-back arbiter for the register-file write port,
//            with a busy scoreboard that stalls issue on long-latency hazards.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LONG_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rs1,
  input  logic [AW-1:0]   i_issue_rs2,
  input  logic [AW-1:0]   i_issue_rd,
  input  logic            i_issue_long,
  output logic            o_stall,
  input  logic            i_wba_valid,
  input  logic [AW-1:0]   i_wba_rd,
  input  logic [XLEN-1:0] i_wba_data,
  output logic            o_wba_ready,
  input  logic            i_wbb_valid,
  input  logic [AW-1:0]   i_wbb_rd,
  input  logic [XLEN-1:0] i_wbb_data,
  output logic            o_wbb_ready,
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata
);

  localparam int            CW         = $clog2(LONG_MAX + 1);
  localparam logic [CW-1:0] C_LONG_MAX = CW'(LONG_MAX);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  logic            r_last_b;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_src_b;
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_outstanding;

  logic            w_grant_a;
  logic            w_grant_b;
  logic [AW-1:0]   w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_rs1_hz;
  logic            w_rs2_hz;
  logic            w_waw;
  logic            w_full;
  logic            w_long_acc;
  logic [NREG-1:0] w_busy_next;
  logic [CW-1:0]   w_cnt_next;

  // A wins a tie only when B took the previous grant.
  assign w_grant_a   = i_wba_valid && (!i_wbb_valid || r_last_b);
  assign w_grant_b   = i_wbb_valid && !w_grant_a;
  assign o_wba_ready = w_grant_a;
  assign o_wbb_ready = w_grant_b;

  assign w_wr_rd   = w_grant_b ? i_wbb_rd   : i_wba_rd;
  assign w_wr_data = w_grant_b ? i_wbb_data : i_wba_data;

  assign w_rs1_hz = (i_issue_rs1 != '0) && r_busy[i_issue_rs1];
  assign w_rs2_hz = (i_issue_rs2 != '0) && r_busy[i_issue_rs2];
  assign w_waw    = r_busy[i_issue_rd];
  assign w_full   = (r_outstanding == C_LONG_MAX);

  assign o_stall    = i_issue_valid &&
                      (w_rs1_hz || w_rs2_hz || (i_issue_long && (w_waw || w_full)));
  assign w_long_acc = i_issue_valid && !o_stall && i_issue_long;

  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;

  // Clear on landing first so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_rf_we && r_src_b) begin
      w_busy_next[r_rf_waddr] = 1'b0;
    end
    if (w_long_acc && (i_issue_rd != '0)) begin
      w_busy_next[i_issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_cnt_next = r_outstanding;
    if (w_long_acc && !w_grant_b && (r_outstanding != C_LONG_MAX)) begin
      w_cnt_next = r_outstanding + C_ONE;
    end else if (!w_long_acc && w_grant_b && (r_outstanding != '0)) begin
      w_cnt_next = r_outstanding - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b      <= 1'b1;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_src_b       <= 1'b0;
      r_busy        <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_grant_a || w_grant_b) begin
        r_last_b <= w_grant_b;
      end
      // Writes to x0 complete the handshake but never reach the RF.
      if ((w_grant_a || w_grant_b) && (w_wr_rd != '0)) begin
        r_rf_we    <= 1'b1;
        r_rf_waddr <= w_wr_rd;
        r_rf_wdata <= w_wr_data;
        r_src_b    <= w_grant_b;
      end else begin
        r_rf_we <= 1'b0;
        r_src_b <= 1'b0;
      end
      r_busy        <= w_busy_next;
      r_outstanding <= w_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// Directed bench for rf_wb_scheduler: expected RF writes are queued at each
// handshake and compared when they appear on the write port.
module tb_rf_wb_scheduler;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic            issue_long;
  logic            stall;
  logic            wba_valid, wbb_valid;
  logic [AW-1:0]   wba_rd, wbb_rd;
  logic [XLEN-1:0] wba_data, wbb_data;
  logic            wba_ready, wbb_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t            sb_q[$];
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  int              n_vec;
  int              n_err;

  rf_wb_scheduler #(.XLEN(XLEN), .NREG(32), .AW(AW), .LONG_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue_valid(issue_valid),
    .i_issue_rs1  (issue_rs1),
    .i_issue_rs2  (issue_rs2),
    .i_issue_rd   (issue_rd),
    .i_issue_long (issue_long),
    .o_stall      (stall),
    .i_wba_valid  (wba_valid),
    .i_wba_rd     (wba_rd),
    .i_wba_data   (wba_data),
    .o_wba_ready  (wba_ready),
    .i_wbb_valid  (wbb_valid),
    .i_wbb_rd     (wbb_rd),
    .i_wbb_data   (wbb_data),
    .o_wbb_ready  (wbb_ready),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic lng, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
    issue_valid = v;
    issue_long  = lng;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
  endtask

  // One clock cycle: inputs are already driven at the preceding negedge.
  task automatic cycle(input logic exp_stall, input logic exp_ga, input logic exp_gb,
                       input string tag);
    exp_t e;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
    #1;
    chk({31'd0, stall},     {31'd0, exp_stall}, {tag, ".stall"});
    chk({31'd0, wba_ready}, {31'd0, exp_ga},    {tag, ".a_ready"});
    chk({31'd0, wbb_ready}, {31'd0, exp_gb},    {tag, ".b_ready"});
    rd   = exp_gb ? wbb_rd   : wba_rd;
    data = exp_gb ? wbb_data : wba_data;
    if ((exp_ga || exp_gb) && (rd != '0)) begin
      m_addr = rd;
      m_data = data;
      sb_q.push_back('{we: 1'b1, addr: rd, data: data});
    end else begin
      sb_q.push_back('{we: 1'b0, addr: m_addr, data: m_data});
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({31'd0, rf_we},           {31'd0, e.we},   {tag, ".rf_we"});
    chk({{(32-AW){1'b0}}, rf_waddr}, {{(32-AW){1'b0}}, e.addr}, {tag, ".rf_waddr"});
    chk(rf_wdata, e.data, {tag, ".rf_wdata"});
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_addr = '0;
    m_data = '0;
    rst_n = 1'b1;
    issue(1'b0, 1'b0, '0, '0, '0);
    wba_valid = 1'b0; wba_rd = '0; wba_data = '0;
    wbb_valid = 1'b0; wbb_rd = '0; wbb_data = '0;
    #1 rst_n = 1'b0;
    #1;
    chk({31'd0, rf_we}, 32'd0, "por.rf_we");
    chk({27'd0, rf_waddr}, 32'd0, "por.rf_waddr");
    chk(rf_wdata, 32'd0, "por.rf_wdata");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-write clears the write port without a clock.
    wba_valid = 1'b1; wba_rd = 5'd9; wba_data = 32'h99;
    cycle(1'b0, 1'b1, 1'b0, "rst_pre");
    wba_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({31'd0, rf_we}, 32'd0, "rst_async.rf_we");
    chk({27'd0, rf_waddr}, 32'd0, "rst_async.rf_waddr");
    chk(rf_wdata, 32'd0, "rst_async.rf_wdata");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    m_addr = '0;
    m_data = '0;
    issue(1'b1, 1'b1, 5'd7, 5'd9, 5'd9);
    #1;
    chk({31'd0, stall}, 32'd0, "rst_post.stall");
    issue(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);

    // Contention: round-robin starting with A.
    wba_valid = 1'b1; wba_rd = 5'd5; wba_data = 32'h11;
    wbb_valid = 1'b1; wbb_rd = 5'd6; wbb_data = 32'h22;
    cycle(1'b0, 1'b1, 1'b0, "rr0");
    cycle(1'b0, 1'b0, 1'b1, "rr1");
    cycle(1'b0, 1'b1, 1'b0, "rr2");
    cycle(1'b0, 1'b0, 1'b1, "rr3");
    wba_valid = 1'b0; wbb_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "rr_idle");

    // RAW on a long-latency destination.
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
    cycle(1'b0, 1'b0, 1'b0, "raw_long");
    issue(1'b1, 1'b0, 5'd7, 5'd0, 5'd10);
    wbb_valid = 1'b1; wbb_rd = 5'd7; wbb_data = 32'h77;
    cycle(1'b1, 1'b0, 1'b1, "raw_hs");
    wbb_valid = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, "raw_land");
    cycle(1'b0, 1'b0, 1'b0, "raw_free");
    issue(1'b0, 1'b0, '0, '0, '0);

    // x0 handling.
    wba_valid = 1'b1; wba_rd = 5'd0; wba_data = 32'hDEADBEEF;
    cycle(1'b0, 1'b1, 1'b0, "x0_wba");
    wba_valid = 1'b0;
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, "x0_long");
    issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd1);
    cycle(1'b0, 1'b0, 1'b0, "x0_rs1");
    issue(1'b0, 1'b0, '0, '0, '0);
    wbb_valid = 1'b1; wbb_rd = 5'd0; wbb_data = 32'h5;
    cycle(1'b0, 1'b0, 1'b1, "x0_wbb");
    wbb_valid = 1'b0;

    // Long-op queue full.
    for (int r = 1; r <= 4; r++) begin
      issue(1'b1, 1'b1, 5'd0, 5'd0, AW'(r));
      cycle(1'b0, 1'b0, 1'b0, $sformatf("full_fill%0d", r));
    end
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd8);
    cycle(1'b1, 1'b0, 1'b0, "full_stall");
    wbb_valid = 1'b1; wbb_rd = 5'd1; wbb_data = 32'hA1;
    cycle(1'b1, 1'b0, 1'b1, "full_hs");
    wbb_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "full_accept");
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd9);
    cycle(1'b1, 1'b0, 1'b0, "full_again");
    issue(1'b0, 1'b0, '0, '0, '0);

    // Drain, then same-cycle set/clear on x3.
    wbb_valid = 1'b1;
    wbb_rd = 5'd2; wbb_data = 32'hB2; cycle(1'b0, 1'b0, 1'b1, "drain2");
    wbb_rd = 5'd3; wbb_data = 32'hB3; cycle(1'b0, 1'b0, 1'b1, "drain3");
    wbb_rd = 5'd4; wbb_data = 32'hB4; cycle(1'b0, 1'b0, 1'b1, "drain4");
    wbb_rd = 5'd8; wbb_data = 32'hB8; cycle(1'b0, 1'b0, 1'b1, "drain8");
    wbb_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "drain_idle0");
    cycle(1'b0, 1'b0, 1'b0, "drain_idle1");
    wbb_valid = 1'b1; wbb_rd = 5'd3; wbb_data = 32'h33;
    cycle(1'b0, 1'b0, 1'b1, "sc_hs");
    wbb_valid = 1'b0;
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
    cycle(1'b0, 1'b0, 1'b0, "sc_setclr");
    issue(1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
    cycle(1'b1, 1'b0, 1'b0, "sc_rs2_0");
    cycle(1'b1, 1'b0, 1'b0, "sc_rs2_1");
    issue(1'b0, 1'b0, '0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
